mem_bus_arbiter: RTL and testbench

//  Parametrised N-channel arbiter that shares one rfin/wfin-handshake memory port between

---
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one rfin/wfin-handshake memory port between NUM_CH pipeline masters.
//   Only one transaction is in flight at a time. Channel 0 has the highest fixed
//   priority unless ARB_ROUND_ROBIN_EN is defined, which selects round-robin grant.
//
// Handshake (all channels and the memory side): a master raises read_ce or
// write_ce as a level and holds it, with address/data stable, until it sees its
// one-cycle rfin/wfin pulse; it must drop the strobe in that fin cycle. Requests
// are sampled only while the arbiter is idle.
//
// Ports
//   clk, rst                  core clock, synchronous active-low reset
//   ch_read_ce / ch_write_ce  per-channel request levels
//   ch_addr / ch_wdata        packed per-channel address / write data
//   ch_rdata                  shared read data, valid with ch_rfin
//   ch_rfin / ch_wfin         one-cycle done pulses to the granted channel
//   ch_err                    set with a fin pulse that ended by timeout
//   mem_*                     downstream memory port
//   dbg_state                 current FSM state (0 idle, 1 wait, 2 done)
//
// Configuration macro: ARB_ROUND_ROBIN_EN (undefined = fixed priority)
module mem_bus_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read_ce,
  input  logic [NUM_CH-1:0]        ch_write_ce,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rfin,
  output logic [NUM_CH-1:0]        ch_wfin,
  output logic                     ch_err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_read_ce,
  output logic                     mem_write_ce,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rfin,
  input  logic                     mem_wfin,
  output logic [1:0]               dbg_state
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   gnt_q;
  logic            wr_q;
  logic [CW-1:0]   cnt_q;

  logic [NUM_CH-1:0] req;
  logic [GW-1:0]     win;
  logic              fin_hit;
  logic              expire;

  assign req       = ch_read_ce | ch_write_ce;
  assign dbg_state = state_q;
  // Only the fin that matches the latched direction completes the transaction.
  assign fin_hit   = wr_q ? mem_wfin : mem_rfin;
  // cnt_q counts WAIT cycles already spent, so expiry fires in the
  // TIMEOUT_CYC-th WAIT cycle.
  assign expire    = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_q;

  // Search starts at the pointer and wraps around the channel list.
  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end
`else
  // Lowest requesting index wins.
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = GW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      ch_rdata     <= '0;
      ch_rfin      <= '0;
      ch_wfin      <= '0;
      ch_err       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read_ce  <= 1'b0;
      mem_write_ce <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q        <= '0;
`endif
    end else begin
      // Fin and error are single-cycle pulses.
      ch_rfin <= '0;
      ch_wfin <= '0;
      ch_err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q        <= win;
            // A channel raising both strobes is treated as a write.
            wr_q         <= ch_write_ce[win];
            mem_addr     <= ch_addr[int'(win)*ADDR_W +: ADDR_W];
            mem_wdata    <= ch_wdata[int'(win)*DATA_W +: DATA_W];
            mem_write_ce <= ch_write_ce[win];
            mem_read_ce  <= !ch_write_ce[win];
            cnt_q        <= '0;
            state_q      <= S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q        <= (win == GW'(NUM_CH - 1)) ? '0 : win + 1'b1;
`endif
          end
        end
        S_WAIT: begin
          if (fin_hit) begin
            mem_read_ce    <= 1'b0;
            mem_write_ce   <= 1'b0;
            if (!wr_q) ch_rdata <= mem_rdata;
            ch_rfin[gnt_q] <= !wr_q;
            ch_wfin[gnt_q] <= wr_q;
            state_q        <= S_DONE;
          end else if (expire) begin
            mem_read_ce    <= 1'b0;
            mem_write_ce   <= 1'b0;
            ch_rdata       <= '1;
            ch_err         <= 1'b1;
            ch_rfin[gnt_q] <= !wr_q;
            ch_wfin[gnt_q] <= wr_q;
            state_q        <= S_DONE;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (NUM_CH=4, TIMEOUT_CYC=4). Inputs are driven and
// outputs sampled on the falling clock edge. The sequencer plays masters and
// memory; a separate monitor checks every fin pulse against the expected queue.
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_read_ce, ch_write_ce;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wdata;
  logic [DW-1:0]   ch_rdata;
  logic [N-1:0]    ch_rfin, ch_wfin;
  logic            ch_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_read_ce, mem_write_ce;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rfin, mem_wfin;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ch_read_ce(ch_read_ce), .ch_write_ce(ch_write_ce),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_rfin(ch_rfin), .ch_wfin(ch_wfin), .ch_err(ch_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_ce(mem_read_ce), .mem_write_ce(mem_write_ce),
    .mem_rdata(mem_rdata), .mem_rfin(mem_rfin), .mem_wfin(mem_wfin),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int passed = 0;

  // Expected fin: {channel[3:0], is_write, err, rdata}
  typedef logic [DW+5:0] exp_t;
  exp_t exp_q[$];

  // Reference model state: pending requests per channel and the RR pointer.
  bit [N-1:0]    pend;
  bit            op_wr[N];
  logic [AW-1:0] r_addr[N];
  logic [DW-1:0] r_wdata[N];
  int            rereq[N];
  int            model_p;

  int            knob_mode;
  int            knob_l;
  bit            knob_data_en;
  logic [DW-1:0] knob_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_req(input int c, input bit wr, input bit both, input logic [AW-1:0] a);
    op_wr[c]   = wr;
    r_addr[c]  = a;
    r_wdata[c] = $urandom;
    pend[c]    = 1'b1;
    ch_addr[c*AW +: AW]  = a;
    ch_wdata[c*DW +: DW] = r_wdata[c];
    ch_write_ce[c] = wr;
    ch_read_ce[c]  = !wr || both;
  endtask

  function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      int c;
      c = (model_p + k) % N;
      if (pend[c]) return c;
    end
`else
    for (int c = 0; c < N; c++) if (pend[c]) return c;
`endif
    return 0;
  endfunction

  task automatic drop(input int g);
    ch_read_ce[g]  = 1'b0;
    ch_write_ce[g] = 1'b0;
    pend[g]        = 1'b0;
  endtask

  // Serve the next transaction the model says should win; called at a negedge
  // while the DUT is idle or in its fin cycle.
  task automatic serve_one();
    int g, mode, l, w;
    bit wr, to, given;
    logic [DW-1:0] d;
    g  = pick();
    wr = op_wr[g];
`ifdef ARB_ROUND_ROBIN_EN
    model_p = (g + 1) % N;
`endif
    w = 0;
    // Stray fins while idle must be ignored.
    while (!(mem_read_ce || mem_write_ce) && w < 20) begin
      mem_rfin  = 1'($urandom);
      mem_wfin  = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      mem_rfin = 1'b0;
      mem_wfin = 1'b0;
      w++;
    end
    if (w == 20) begin
      chk("grant_wait", 0, 1);
      drop(g);
      return;
    end
    chk("mem_addr", mem_addr, r_addr[g]);
    chk("mem_op", {mem_read_ce, mem_write_ce}, wr ? 2'b01 : 2'b10);
    if (wr) chk("mem_wdata", mem_wdata, r_wdata[g]);
    mode = (knob_mode >= 0) ? knob_mode : $urandom_range(0, 3);
    to   = (mode == 3);
    l    = (mode == 2) ? TO - 1 : ((knob_l >= 0) ? knob_l : $urandom_range(0, TO - 2));
    d    = knob_data_en ? knob_data : $urandom;
    exp_q.push_back({4'(g), wr, to, to ? {DW{1'b1}} : d});
    given = 1'b0;
    for (int c = 0; c < TO; c++) begin
      chk("ce_held", {mem_read_ce, mem_write_ce}, wr ? 2'b01 : 2'b10);
      chk("addr_held", mem_addr, r_addr[g]);
      if (!to && c == l) begin
        given = 1'b1;
        if (wr) mem_wfin = 1'b1;
        else begin
          mem_rfin  = 1'b1;
          mem_rdata = d;
        end
      end else begin
        // Opposite-direction fin must not complete the transaction.
        if (wr) mem_rfin = 1'($urandom);
        else    mem_wfin = 1'($urandom);
        mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_rfin = 1'b0;
      mem_wfin = 1'b0;
      if (given) break;
    end
    chk("ce_dropped", {mem_read_ce, mem_write_ce}, 2'b00);
    chk("fin_latency", wr ? ch_wfin[g] : ch_rfin[g], 1);
    drop(g);
    if (rereq[g] > 0) begin
      rereq[g]--;
      set_req(g, op_wr[g], 1'b0, $urandom);
    end
  endtask

  task automatic serve_all();
    while (pend != '0) serve_one();
  endtask

  task automatic clear_knobs();
    knob_mode    = -1;
    knob_l       = -1;
    knob_data_en = 1'b0;
    knob_data    = '0;
  endtask

  // Monitor: every fin pulse must match the head of the expected queue.
  exp_t m_e;
  int   m_g;
  always @(negedge clk) begin
    if (ch_rfin != '0 || ch_wfin != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fin", {ch_rfin, ch_wfin}, 0);
      end else begin
        m_e = exp_q.pop_front();
        m_g = int'(m_e[DW+5:DW+2]);
        chk("rfin_vec", ch_rfin, m_e[DW+1] ? 0 : (1 << m_g));
        chk("wfin_vec", ch_wfin, m_e[DW+1] ? (1 << m_g) : 0);
        chk("fin_err", ch_err, m_e[DW]);
        if (!m_e[DW+1]) chk("rdata", ch_rdata, m_e[DW-1:0]);
      end
    end else if (ch_err) begin
      chk("err_without_fin", ch_err, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ch_read_ce = '0; ch_write_ce = '0; ch_addr = '0; ch_wdata = '0;
    mem_rdata = '0; mem_rfin = 1'b0; mem_wfin = 1'b0;
    pend = '0; model_p = 0;
    for (int i = 0; i < N; i++) begin
      rereq[i] = 0; op_wr[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    clear_knobs();

    // Reset with every request asserted: nothing may come out.
    ch_read_ce = '1; ch_write_ce = '1; ch_addr = '1; ch_wdata = '1;
    mem_rfin = 1'b1; mem_wfin = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctl", {mem_read_ce, mem_write_ce, ch_rfin, ch_wfin, ch_err, dbg_state}, 0);
      chk("reset_data", {mem_addr, ch_rdata}, 0);
      chk("reset_wdata", mem_wdata, 0);
    end
    ch_read_ce = '0; ch_write_ce = '0; mem_rfin = 1'b0; mem_wfin = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {mem_read_ce, mem_write_ce}, 0);

    // Single read on ch1, fin in the second WAIT cycle.
    knob_mode = 0; knob_l = 1; knob_data_en = 1'b1; knob_data = 32'hDEAD_BEEF;
    set_req(1, 1'b0, 1'b0, 32'h8000_0010);
    serve_all();
    clear_knobs();
    @(negedge clk);

    // ch0 and ch1 write continuously: fixed starves ch1, RR alternates.
    set_req(0, 1'b1, 1'b0, $urandom); rereq[0] = 3;
    set_req(1, 1'b1, 1'b0, $urandom); rereq[1] = 3;
    serve_all();
    @(negedge clk);

    // Timeout with no fin, then fin landing exactly on the expiry cycle.
    knob_mode = 3;
    set_req(2, 1'b0, 1'b0, $urandom);
    serve_all();
    knob_mode = 2; knob_data_en = 1'b1; knob_data = 32'h1234_5678;
    set_req(2, 1'b0, 1'b0, $urandom);
    serve_all();
    knob_mode = 3;
    set_req(1, 1'b1, 1'b0, $urandom);
    serve_all();
    clear_knobs();
    @(negedge clk);

    // Reset during WAIT abandons the transaction; a late fin produces nothing.
    set_req(2, 1'b0, 1'b0, $urandom);
    for (int w = 0; w < 20 && !mem_read_ce; w++) @(negedge clk);
    chk("wait_entered", mem_read_ce, 1);
    @(negedge clk);
    rst = 1'b0;
    drop(2);
    @(negedge clk);
    chk("reset_in_wait", {mem_read_ce, mem_write_ce, dbg_state}, 0);
    rst = 1'b1;
    model_p = 0;
    mem_rfin = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rfin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_fin_after_reset", {ch_rfin, ch_wfin, mem_read_ce}, 0);
    end
    set_req(2, 1'b0, 1'b0, $urandom);
    serve_all();
    @(negedge clk);

    // Grant to ch3, then 4'b1001 must go to ch0 (pointer wraps to 0).
    set_req(3, 1'($urandom), 1'b0, $urandom);
    serve_all();
    set_req(0, 1'($urandom), 1'b0, $urandom);
    set_req(3, 1'($urandom), 1'b0, $urandom);
    serve_all();

    // Randomized bursts of contending requests.
    for (int b = 0; b < 25; b++) begin
      int mask;
      mask = $urandom_range(1, (1 << N) - 1);
      for (int c = 0; c < N; c++) begin
        if (mask[c]) begin
          bit wr;
          wr = 1'($urandom);
          set_req(c, wr, wr && ($urandom_range(0, 3) == 0), $urandom);
          rereq[c] = $urandom_range(0, 2);
        end
      end
      serve_all();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
